// File: rtl/io_sw_conditioner.sv
// io_sw_conditioner: brings raw board switches into the core clock domain,
// debounces every bit against a shared prescaled tick, and emits a clean
// registered word plus per-bit rise/fall pulses and a summary event flag.
module io_sw_conditioner #(
  parameter int WIDTH        = 32,
  parameter int TICK_DIV     = 50000,
  parameter int STABLE_TICKS = 10
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_sw_raw,
  output logic [WIDTH-1:0] o_io_sw,
  output logic [WIDTH-1:0] o_sw_rise,
  output logic [WIDTH-1:0] o_sw_fall,
  output logic             o_sw_event
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(STABLE_TICKS - 1);

  logic [WIDTH-1:0]         sync1;
  logic [WIDTH-1:0]         sync2;
  logic [PW-1:0]            presc;
  logic                     tick;
  logic [WIDTH-1:0][CW-1:0] cnt;
  logic [WIDTH-1:0][CW-1:0] cnt_next;
  logic [WIDTH-1:0]         debounced;
  logic [WIDTH-1:0]         deb_next;
  logic [WIDTH-1:0]         rise_next;
  logic [WIDTH-1:0]         fall_next;

  assign tick = (presc == PRESC_LAST);

  // Two-flop synchronizer per bit, nothing between the stages.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= i_sw_raw;
      sync2 <= sync1;
    end
  end

  // Free-running prescaler; tick marks its last count and is never restarted by input activity.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // Per-bit qualification: any agreement clears the count, enough consecutive disagreeing ticks flip the bit.
  always_comb begin
    cnt_next  = cnt;
    deb_next  = debounced;
    rise_next = '0;
    fall_next = '0;
    for (int b = 0; b < WIDTH; b++) begin
      if (sync2[b] == debounced[b]) begin
        cnt_next[b] = '0;
      end else if (tick && (cnt[b] == CNT_LAST)) begin
        deb_next[b]  = sync2[b];
        cnt_next[b]  = '0;
        rise_next[b] = sync2[b];
        fall_next[b] = ~sync2[b];
      end else if (tick) begin
        cnt_next[b] = cnt[b] + 1'b1;
      end
    end
  end

  // Debounce state and all outputs are registered so the pulses line up with the new word.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt        <= '0;
      debounced  <= '0;
      o_sw_rise  <= '0;
      o_sw_fall  <= '0;
      o_sw_event <= 1'b0;
    end else begin
      cnt        <= cnt_next;
      debounced  <= deb_next;
      o_sw_rise  <= rise_next;
      o_sw_fall  <= fall_next;
      o_sw_event <= |(rise_next | fall_next);
    end
  end

  assign o_io_sw = debounced;

endmodule

// File: tb/tb_io_sw_conditioner.sv
// tb_io_sw_conditioner: drives directed and random switch patterns into a
// TICK_DIV=4/STABLE_TICKS=3 instance and a TICK_DIV=1/STABLE_TICKS=1 instance,
// predicting each cycle's outputs from a behavioural model and checking them
// through a queue-based scoreboard.
module tb_io_sw_conditioner;

  localparam int W  = 32;
  localparam int TD = 4;
  localparam int ST = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  raw;

  logic [W-1:0]  sw_m, rise_m, fall_m;
  logic          ev_m;
  logic [W-1:0]  sw_d, rise_d, fall_d;
  logic          ev_d;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [31:0]      s1;
    logic [31:0]      s2;
    logic [31:0]      deb;
    logic [31:0]      rise;
    logic [31:0]      fall;
    logic [31:0][7:0] run;
    int               cycles;
  } model_t;

  typedef struct packed {
    logic [31:0] sw;
    logic [31:0] rise;
    logic [31:0] fall;
    logic        ev;
  } exp_t;

  model_t mm;
  model_t md;
  exp_t   q_m[$];
  exp_t   q_d[$];

  io_sw_conditioner #(.WIDTH(W), .TICK_DIV(TD), .STABLE_TICKS(ST)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_sw_raw   (raw),
    .o_io_sw    (sw_m),
    .o_sw_rise  (rise_m),
    .o_sw_fall  (fall_m),
    .o_sw_event (ev_m)
  );

  io_sw_conditioner #(.WIDTH(W), .TICK_DIV(1), .STABLE_TICKS(1)) dut_deg (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_sw_raw   (raw),
    .o_io_sw    (sw_d),
    .o_sw_rise  (rise_d),
    .o_sw_fall  (fall_d),
    .o_sw_event (ev_d)
  );

  always #5 clk = ~clk;

  // One clock edge of the reference behaviour: ticks are every td-th cycle since reset,
  // and a bit adopts the synchronized level once st ticks pass with no agreement in between.
  function automatic model_t model_step(input model_t m, input logic [31:0] r,
                                        input logic rs, input int td, input int st);
    model_t n;
    bit     tick;
    n      = m;
    n.rise = '0;
    n.fall = '0;
    if (rs) begin
      n = '0;
      return n;
    end
    tick = ((m.cycles % td) == (td - 1));
    for (int b = 0; b < 32; b++) begin
      if (m.s2[b] == m.deb[b]) begin
        n.run[b] = 8'd0;
      end else if (tick) begin
        if (int'(m.run[b]) + 1 >= st) begin
          n.deb[b]  = m.s2[b];
          n.rise[b] = m.s2[b];
          n.fall[b] = ~m.s2[b];
          n.run[b]  = 8'd0;
        end else begin
          n.run[b] = m.run[b] + 8'd1;
        end
      end
    end
    n.s2     = m.s1;
    n.s1     = r;
    n.cycles = m.cycles + 1;
    return n;
  endfunction

  // Advance both models on every edge and queue what each DUT should show afterwards.
  always @(posedge clk) begin
    exp_t e;
    mm     = model_step(mm, raw, rst, TD, ST);
    md     = model_step(md, raw, rst, 1, 1);
    e.sw   = mm.deb;
    e.rise = mm.rise;
    e.fall = mm.fall;
    e.ev   = |(mm.rise | mm.fall);
    q_m.push_back(e);
    e.sw   = md.deb;
    e.rise = md.rise;
    e.fall = md.fall;
    e.ev   = |(md.rise | md.fall);
    q_d.push_back(e);
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Monitor: pop the expectation for each finished edge and compare mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (q_m.size() > 0) begin
      e = q_m.pop_front();
      checkOutput("main.o_io_sw",     sw_m,        e.sw);
      checkOutput("main.o_sw_rise",   rise_m,      e.rise);
      checkOutput("main.o_sw_fall",   fall_m,      e.fall);
      checkOutput("main.o_sw_event",  32'(ev_m),   32'(e.ev));
    end
    if (q_d.size() > 0) begin
      e = q_d.pop_front();
      checkOutput("deg.o_io_sw",      sw_d,        e.sw);
      checkOutput("deg.o_sw_rise",    rise_d,      e.rise);
      checkOutput("deg.o_sw_fall",    fall_d,      e.fall);
      checkOutput("deg.o_sw_event",   32'(ev_d),   32'(e.ev));
    end
  end

  task automatic applyStimulus(input logic [31:0] r, input logic rs, input int cycles);
    raw = r;
    rst = rs;
    repeat (cycles) @(posedge clk);
    #2;
  endtask

  // Directed scenarios first, then sparse random flips with varied hold times and occasional resets.
  initial begin
    logic [31:0] cur;
    mm  = '0;
    md  = '0;
    rst = 1'b1;
    raw = '1;
    $display("[TB] start");

    applyStimulus(32'hFFFF_FFFF, 1'b1, 2);
    applyStimulus(32'hFFFF_FFFF, 1'b0, 20);
    applyStimulus(32'h0000_0000, 1'b0, 20);

    for (int k = 0; k < 4; k++) begin
      applyStimulus(32'h0000_0000, 1'b0, k + 1);
      applyStimulus(32'h0000_0020, 1'b0, 20);
      applyStimulus(32'h0000_0000, 1'b0, 20);
    end

    repeat (5) begin
      applyStimulus(32'h0000_0001, 1'b0, 7);
      applyStimulus(32'h0000_0000, 1'b0, 1);
    end
    applyStimulus(32'h0000_0001, 1'b0, 20);
    applyStimulus(32'h0000_0000, 1'b0, 20);

    applyStimulus(32'h0000_00F0, 1'b0, 20);
    applyStimulus(32'h0000_000F, 1'b0, 20);
    applyStimulus(32'h0000_0000, 1'b0, 20);

    applyStimulus(32'h0000_0008, 1'b0, 9);
    applyStimulus(32'h0000_0008, 1'b1, 1);
    applyStimulus(32'h0000_0008, 1'b0, 20);
    applyStimulus(32'h0000_0000, 1'b0, 20);

    applyStimulus(32'h8000_0000, 1'b0, 5);
    applyStimulus(32'h0000_0000, 1'b0, 5);
    applyStimulus(32'h8000_0000, 1'b0, 1);
    applyStimulus(32'h0000_0000, 1'b0, 6);

    cur = '0;
    repeat (150) begin
      cur = cur ^ ($urandom & $urandom & $urandom);
      if ($urandom_range(0, 39) == 0) begin
        applyStimulus(cur, 1'b1, $urandom_range(1, 2));
      end
      applyStimulus(cur, 1'b0, $urandom_range(1, 20));
    end
    applyStimulus(cur, 1'b0, 3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
